// File: rtl/rs_pkg.sv
// Shared constants, GF(2^8) multiply and FSM state type for the RS(255,239) syndrome front end.
package rs_pkg;
  localparam int SYM_W = 8;
  localparam int N     = 255;
  localparam int T     = 8;
  localparam int DEG_W = 6;
  localparam int CNT_W = 8;
  localparam int K_W   = $clog2(2*T+1);
  localparam int IDX_W = $clog2(2*T);

  localparam logic [SYM_W:0] PRIM_POLY = 9'h11D;

  // alpha^j for j = 1..2T over 0x11D
  localparam logic [2*T:1][SYM_W-1:0] ALPHA_POW = {
    8'h4C, 8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A,
    8'h1D, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02
  };

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ PRIM_POLY[SYM_W-1:0]) : (x << 1);
    end
    return p;
  endfunction
endpackage

// File: rtl/rs_synd_cell.sv
// One Horner syndrome accumulator: S <= S*ROOT ^ din, or S <= din on a load beat.
module rs_synd_cell
  import rs_pkg::*;
#(
  parameter logic [SYM_W-1:0] ROOT = 8'h02
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] din,
  input  logic             load,
  input  logic             acc,
  output logic [SYM_W-1:0] s_o,
  output logic [SYM_W-1:0] s_next_o
);
  logic [SYM_W-1:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (load)     s_d = din;
    else if (acc) s_d = gf_mul(s_q, ROOT) ^ din;
  end

  always_ff @(posedge clk) begin
    if (reset) s_q <= '0;
    else       s_q <= s_d;
  end

  assign s_o      = s_q;
  assign s_next_o = s_d;
endmodule

// File: rtl/rs_syndrome_feeder.sv
// Syndrome accumulation, shadow snapshot and serialization of R0/Q0/L0/U0 into the Euclidean array.
// Build option SYND_ZERO_SKIP_EN: suppress the frame for all-zero syndromes (no_err still pulses).
module rs_syndrome_feeder
  import rs_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_sop,
  output logic [SYM_W-1:0] Rout,
  output logic [SYM_W-1:0] Qout,
  output logic [SYM_W-1:0] Lout,
  output logic [SYM_W-1:0] Uout,
  output logic [DEG_W-1:0] deg_Ro,
  output logic [DEG_W-1:0] deg_Qo,
  output logic             start_o,
  output logic             start_cnt_o,
  output logic             stop_o,
  output logic             no_err,
  output logic             synd_ovf
);
`ifdef SYND_ZERO_SKIP_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  logic [2*T-1:0][SYM_W-1:0] s_next, s_cur, sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vld_pipe_q, vld_pipe_d;  // [0]: snapshot taken, [1]: frame launch
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             load, acc, snap, busy, snap_ok;
  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0] qidx;

  logic [SYM_W-1:0] rout_q, rout_d, qout_q, qout_d, uout_q, uout_d;
  logic [DEG_W-1:0] dr_q, dr_d, dq_q, dq_d;
  logic             start_q, start_d, en_q, en_d, noerr_q, noerr_d;

  assign load = din_valid && din_sop;
  assign acc  = din_valid && !din_sop && (cnt_q != '0);
  assign snap = acc && (cnt_q == CNT_W'(N-1));

  for (genvar j = 0; j < 2*T; j++) begin : g_cell
    rs_synd_cell #(.ROOT(ALPHA_POW[j+1])) u_cell (
      .clk     (clk),
      .reset   (reset),
      .din     (din),
      .load    (load),
      .acc     (acc),
      .s_o     (s_cur[j]),
      .s_next_o(s_next[j])
    );
  end

  // A snapshot landing on a frame still being launched or sent is dropped.
  assign busy    = (state_q == ST_SEND) || vld_pipe_q[0];
  assign snap_ok = snap && !busy;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = CNT_W'(1);
    else if (acc) cnt_d = snap ? '0 : cnt_q + CNT_W'(1);
    sh_d       = snap_ok ? s_next : sh_q;
    zero_d     = snap_ok ? (s_next == '0) : zero_q;
    ovf_d      = ovf_q | (snap && busy);
    vld_pipe_d = {vld_pipe_q[0], snap_ok};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: if (vld_pipe_q[0] && !(SKIP_ZERO && zero_q)) begin
        state_d = ST_SEND;
        k_d     = K_W'(2*T);
      end
      ST_SEND: begin
        if (k_q == '0) state_d = ST_IDLE;
        else           k_d     = k_q - K_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign qidx = IDX_W'(k_q - K_W'(1));

  always_comb begin
    rout_d  = '0;
    qout_d  = '0;
    uout_d  = '0;
    dr_d    = '0;
    dq_d    = '0;
    start_d = 1'b0;
    en_d    = 1'b0;
    noerr_d = vld_pipe_q[1] && zero_q;
    if (state_q == ST_SEND) begin
      en_d    = 1'b1;
      dr_d    = DEG_W'(2*T);
      dq_d    = DEG_W'(2*T-1);
      start_d = (k_q == K_W'(2*T));
      rout_d  = start_d ? SYM_W'(1) : '0;
      uout_d  = (k_q == '0) ? SYM_W'(1) : '0;
      if (k_q != '0 && !start_d) qout_d = sh_q[qidx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      sh_q       <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      vld_pipe_q <= '0;
      state_q    <= ST_IDLE;
      k_q        <= '0;
      rout_q     <= '0;
      qout_q     <= '0;
      uout_q     <= '0;
      dr_q       <= '0;
      dq_q       <= '0;
      start_q    <= 1'b0;
      en_q       <= 1'b0;
      noerr_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      vld_pipe_q <= vld_pipe_d;
      state_q    <= state_d;
      k_q        <= k_d;
      rout_q     <= rout_d;
      qout_q     <= qout_d;
      uout_q     <= uout_d;
      dr_q       <= dr_d;
      dq_q       <= dq_d;
      start_q    <= start_d;
      en_q       <= en_d;
      noerr_q    <= noerr_d;
    end
  end

  logic unused_s;
  assign unused_s = ^s_cur;

  assign Rout        = rout_q;
  assign Qout        = qout_q;
  assign Lout        = '0;
  assign Uout        = uout_q;
  assign deg_Ro      = dr_q;
  assign deg_Qo      = dq_q;
  assign start_o     = start_q;
  assign start_cnt_o = en_q;
  assign stop_o      = 1'b0;
  assign no_err      = noerr_q;
  assign synd_ovf    = ovf_q;
endmodule

// File: tb/tb_rs_syndrome_feeder.sv
// Scoreboard bench for rs_syndrome_feeder: expected frame beats are queued per codeword and checked on output.
module tb_rs_syndrome_feeder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_sop = 1'b0;
  logic [7:0] Rout, Qout, Lout, Uout;
  logic [5:0] deg_Ro, deg_Qo;
  logic       start_o, start_cnt_o, stop_o, no_err, synd_ovf;

  rs_syndrome_feeder dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_sop(din_sop),
    .Rout(Rout), .Qout(Qout), .Lout(Lout), .Uout(Uout),
    .deg_Ro(deg_Ro), .deg_Qo(deg_Qo), .start_o(start_o), .start_cnt_o(start_cnt_o),
    .stop_o(stop_o), .no_err(no_err), .synd_ovf(synd_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r, q, u;
    logic       st, ne;
  } beat_t;

  beat_t      exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         skip_noerr = 0;
  int         run = 0;
  logic [7:0] cw [0:254];
  logic [7:0] alog [0:254];
  logic [7:0] synd [1:16];

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  // Direct evaluation S_j = sum r_i * alpha^(j*(254-i)).
  task automatic push_expected();
    logic allz;
    beat_t b;
    allz = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      synd[j] = '0;
      for (int i = 0; i < 255; i++) synd[j] ^= mul(cw[i], alog[(j * (254 - i)) % 255]);
      if (synd[j] != 0) allz = 1'b0;
    end
`ifdef SYND_ZERO_SKIP_EN
    if (allz) begin
      skip_noerr++;
      return;
    end
`endif
    for (int k = 16; k >= 0; k--) begin
      b.r  = (k == 16) ? 8'h01 : 8'h00;
      b.q  = (k == 16 || k == 0) ? 8'h00 : synd[k];
      b.u  = (k == 0) ? 8'h01 : 8'h00;
      b.st = (k == 16);
      b.ne = (k == 16) && allz;
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (reset) run = 0;
    else if (start_cnt_o) begin
      run++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: R=%h Q=%h U=%h start=%b, none expected", Rout, Qout, Uout, start_o);
      end else begin
        e = exp_q.pop_front();
        if ({Rout, Qout, Lout, Uout, start_o, no_err, deg_Ro, deg_Qo} !==
            {e.r, e.q, 8'h00, e.u, e.st, e.ne, 6'd16, 6'd15}) begin
          n_fail++;
          $display("FAIL frame_beat: got R=%h Q=%h L=%h U=%h st=%b ne=%b dR=%0d dQ=%0d, want R=%h Q=%h L=00 U=%h st=%b ne=%b dR=16 dQ=15",
                   Rout, Qout, Lout, Uout, start_o, no_err, deg_Ro, deg_Qo, e.r, e.q, e.u, e.st, e.ne);
        end
      end
    end else begin
      if (run != 0) begin
        n_checks++;
        if (run != 17) begin
          n_fail++;
          $display("FAIL frame_len: got %0d, want 17", run);
        end
        run = 0;
      end
      if (no_err) begin
        n_checks++;
        if (skip_noerr > 0) skip_noerr--;
        else begin
          n_fail++;
          $display("FAIL stray_no_err: got 1 outside frame, want 0");
        end
      end
      n_checks++;
      if ({Rout, Qout, Lout, Uout, start_o, deg_Ro, deg_Qo, stop_o} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs: R=%h Q=%h L=%h U=%h st=%b dR=%0d dQ=%0d stop=%b, want all 0",
                 Rout, Qout, Lout, Uout, start_o, deg_Ro, deg_Qo, stop_o);
      end
    end
  end

  task automatic drive_beat(input logic [7:0] s, input logic sop);
    din = s; din_valid = 1'b1; din_sop = sop;
    @(posedge clk); #1;
    din = '0; din_valid = 1'b0; din_sop = 1'b0;
  endtask

  task automatic send_cw(input int gap_pct);
    for (int i = 0; i < 255; i++) begin
      for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
        @(posedge clk); #1;
      end
      drive_beat(cw[i], i == 0);
    end
    push_expected();
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || start_cnt_o || skip_noerr != 0) && c < 3000) begin
      @(negedge clk); c++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || skip_noerr != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats and %0d no_err pulses outstanding, want 0", exp_q.size(), skip_noerr);
      exp_q.delete(); skip_noerr = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({Rout, Qout, Lout, Uout, deg_Ro, deg_Qo, start_o, start_cnt_o, stop_o, no_err, synd_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs %h, want 0",
               {Rout, Qout, Lout, Uout, deg_Ro, deg_Qo, start_o, start_cnt_o, stop_o, no_err, synd_ovf});
    end
    reset = 1'b0;
  endtask

  task automatic test_all_zero();
    // Unqualified beats before any sop must be ignored.
    for (int i = 0; i < 10; i++) drive_beat(8'hA5, 1'b0);
    for (int i = 0; i < 255; i++) cw[i] = '0;
    send_cw(0);
    wait_drain();
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 255; i++) cw[i] = '0;
    cw[0] = 8'h01;
    send_cw(0);
    n_checks++;
    if (synd[1] !== 8'h8E) begin
      n_fail++;
      $display("FAIL model_s1: got %h, want 8e", synd[1]);
    end
    wait_drain();
  endtask

  task automatic test_latency();
    logic [2:0] seen;
    for (int i = 0; i < 255; i++) cw[i] = '0;
    cw[254] = 8'h05;
    send_cw(0);
    @(negedge clk); seen[0] = start_o;
    @(negedge clk); seen[1] = start_o;
    @(negedge clk); seen[2] = start_o;
    n_checks++;
    if (seen !== 3'b100) begin
      n_fail++;
      $display("FAIL latency: start_o over 3 cycles got %b, want 100", seen);
    end
    wait_drain();
  endtask

  task automatic test_random_gaps();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 255; i++) cw[i] = 8'($urandom);
      send_cw(30);
      wait_drain();
    end
  endtask

  task automatic test_mid_sop();
    drive_beat(8'($urandom), 1'b1);
    for (int i = 1; i < 100; i++) drive_beat(8'($urandom), 1'b0);
    for (int i = 0; i < 255; i++) cw[i] = 8'($urandom);
    send_cw(10);
    wait_drain();
    n_checks++;
    if (synd_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sop_ovf: got %b, want 0", synd_ovf);
    end
  endtask

  task automatic test_reset_in_send();
    int c;
    for (int i = 0; i < 255; i++) cw[i] = 8'($urandom);
    send_cw(0);
    c = 0;
    while (!start_cnt_o && c < 20) begin
      @(negedge clk); c++;
    end
    n_checks++;
    if (!start_cnt_o) begin
      n_fail++;
      $display("FAIL reset_send_start: start_cnt_o got 0, want 1");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    n_checks++;
    if ({Rout, Qout, Lout, Uout, deg_Ro, deg_Qo, start_o, start_cnt_o, no_err, synd_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_send: outputs %h, want 0",
               {Rout, Qout, Lout, Uout, deg_Ro, deg_Qo, start_o, start_cnt_o, no_err, synd_ovf});
    end
    reset = 1'b0;
    // Any beat after this point is flagged as unexpected by the scoreboard.
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a;
    a = 8'h01;
    for (int e = 0; e < 255; e++) begin
      alog[e] = a;
      a = mul(a, 8'h02);
    end
    test_reset();
    test_all_zero();
    test_single_error();
    test_latency();
    test_random_gaps();
    test_mid_sop();
    test_reset_in_send();
    n_checks++;
    if (synd_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL final_ovf: got %b, want 0", synd_ovf);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
